// File: rtl/wb_arb_pkg.sv
// Shared types, widths and the rotate-priority helper for the Wishbone arbiter.
package wb_arb_pkg;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SEL_W  = 4;
    localparam int CTI_W  = 3;
    localparam int BTE_W  = 2;
    localparam int WDOG_W = 16;
    localparam int MAX_M  = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        ABORT = 2'b10
    } arb_state_t;

    // Scanning a fixed 8-wide ring is equivalent to a modulo-N scan because unused request bits are zero.
    function automatic logic [MAX_M-1:0] rr_next(input logic [MAX_M-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [MAX_M-1:0] pick;
        logic [IDX_W-1:0] idx;
        pick = '0;
        for (int k = MAX_M; k >= 1; k--) begin
            idx = last + IDX_W'(k);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wishbone_b3.sv
// Wishbone B3 classic/burst bus bundle with master and slave views.
interface wishbone_b3;

    logic                           cyc;
    logic                           stb;
    logic                           we;
    logic [wb_arb_pkg::AW-1:0]      adr;
    logic [wb_arb_pkg::DW-1:0]      dat_m2s;
    logic [wb_arb_pkg::DW-1:0]      dat_s2m;
    logic [wb_arb_pkg::SEL_W-1:0]   sel;
    logic [wb_arb_pkg::CTI_W-1:0]   cti;
    logic [wb_arb_pkg::BTE_W-1:0]   bte;
    logic                           ack;
    logic                           err;
    logic                           rty;

    modport master (
        output cyc, stb, we, adr, dat_m2s, sel, cti, bte,
        input  ack, err, rty, dat_s2m
    );

    modport slave (
        input  cyc, stb, we, adr, dat_m2s, sel, cti, bte,
        output ack, err, rty, dat_s2m
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational rotate-priority encoder: first requester after `last`, wrapping.
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          any
);

    assign pick = N'(rr_next(MAX_M'(req), IDX_W'(last)));
    assign any  = |req;

    // One-hot to binary index of the winner.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            pick_idx = pick_idx | (IW'(i) & {IW{pick[i]}});
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter with per-cycle ownership and a stall watchdog that aborts with err.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int MASTERS = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    wishbone_b3.slave          master [MASTERS],
    wishbone_b3.master         slave,
    output logic [MASTERS-1:0] grant,
    output logic               timeout
);

    localparam int IW = $clog2(MASTERS);

    arb_state_t          state_r;
    logic [MASTERS-1:0]  grant_r;
    logic [IW-1:0]       last_r;
    logic [WDOG_W-1:0]   wdog_r;

    logic [MASTERS-1:0]  m_cyc_s;
    logic [MASTERS-1:0]  m_stb_s;
    logic [MASTERS-1:0]  m_we_s;
    logic [AW-1:0]       m_adr_s [MASTERS];
    logic [DW-1:0]       m_dat_s [MASTERS];
    logic [SEL_W-1:0]    m_sel_s [MASTERS];
    logic [CTI_W-1:0]    m_cti_s [MASTERS];
    logic [BTE_W-1:0]    m_bte_s [MASTERS];

    logic                own_cyc_s;
    logic                own_stb_s;
    logic                own_we_s;
    logic [AW-1:0]       own_adr_s;
    logic [DW-1:0]       own_dat_s;
    logic [SEL_W-1:0]    own_sel_s;
    logic [CTI_W-1:0]    own_cti_s;
    logic [BTE_W-1:0]    own_bte_s;

    logic                in_grant_s;
    logic                in_abort_s;
    logic                term_s;
    logic                stall_s;
    logic                expire_s;
    logic [MASTERS-1:0]  pick_s;
    logic [IW-1:0]       pick_idx_s;
    logic                any_s;

    // Responses only reach the owner; read data is broadcast since non-owners ignore it.
    for (genvar i = 0; i < MASTERS; i++) begin : g_port
        assign m_cyc_s[i] = master[i].cyc;
        assign m_stb_s[i] = master[i].stb;
        assign m_we_s[i]  = master[i].we;
        assign m_adr_s[i] = master[i].adr;
        assign m_dat_s[i] = master[i].dat_m2s;
        assign m_sel_s[i] = master[i].sel;
        assign m_cti_s[i] = master[i].cti;
        assign m_bte_s[i] = master[i].bte;

        assign master[i].ack     = grant_r[i] & in_grant_s & slave.ack;
        assign master[i].err     = grant_r[i] & ((in_grant_s & slave.err) | in_abort_s);
        assign master[i].rty     = grant_r[i] & in_grant_s & slave.rty;
        assign master[i].dat_s2m = slave.dat_s2m;
    end

    rr_picker #(
        .N  (MASTERS),
        .IW (IW)
    ) u_picker (
        .req      (m_cyc_s),
        .last     (last_r),
        .pick     (pick_s),
        .pick_idx (pick_idx_s),
        .any      (any_s)
    );

    // AND-OR mux of the owner's request signals; all-zero when nobody is granted.
    always_comb begin
        own_cyc_s = |(grant_r & m_cyc_s);
        own_stb_s = |(grant_r & m_stb_s);
        own_we_s  = |(grant_r & m_we_s);
        own_adr_s = '0;
        own_dat_s = '0;
        own_sel_s = '0;
        own_cti_s = '0;
        own_bte_s = '0;
        for (int i = 0; i < MASTERS; i++) begin
            own_adr_s = own_adr_s | (m_adr_s[i] & {AW{grant_r[i]}});
            own_dat_s = own_dat_s | (m_dat_s[i] & {DW{grant_r[i]}});
            own_sel_s = own_sel_s | (m_sel_s[i] & {SEL_W{grant_r[i]}});
            own_cti_s = own_cti_s | (m_cti_s[i] & {CTI_W{grant_r[i]}});
            own_bte_s = own_bte_s | (m_bte_s[i] & {BTE_W{grant_r[i]}});
        end
    end

    assign in_grant_s = (state_r == GRANT);
    assign in_abort_s = (state_r == ABORT);

    assign slave.cyc     = in_grant_s & own_cyc_s;
    assign slave.stb     = in_grant_s & own_stb_s;
    assign slave.we      = in_grant_s & own_we_s;
    assign slave.adr     = own_adr_s;
    assign slave.dat_m2s = own_dat_s;
    assign slave.sel     = own_sel_s;
    assign slave.cti     = own_cti_s;
    assign slave.bte     = own_bte_s;

    // A termination in the expiry cycle masks the stall, so the slave wins the race.
    assign term_s   = slave.ack | slave.err | slave.rty;
    assign stall_s  = in_grant_s & own_stb_s & ~term_s;
    assign expire_s = stall_s & (wdog_r == WDOG_W'(TIMEOUT - 1));

    assign grant   = grant_r;
    assign timeout = in_abort_s;

    // Arbitration FSM with owner, rotation pointer and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            grant_r <= '0;
            last_r  <= IW'(MASTERS - 1);
            wdog_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    wdog_r <= '0;
                    if (any_s) begin
                        grant_r <= pick_s;
                        last_r  <= pick_idx_s;
                        state_r <= GRANT;
                    end else begin
                        grant_r <= '0;
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (!own_cyc_s) begin
                        grant_r <= '0;
                        wdog_r  <= '0;
                        state_r <= IDLE;
                    end else if (expire_s) begin
                        wdog_r  <= '0;
                        state_r <= ABORT;
                    end else if (stall_s) begin
                        wdog_r  <= wdog_r + WDOG_W'(1);
                    end else begin
                        wdog_r  <= '0;
                    end
                end
                ABORT: begin
                    grant_r <= '0;
                    wdog_r  <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    grant_r <= '0;
                    wdog_r  <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
